mux_scan_ctrl: RTL and testbench
================================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 2: cycles each select value is held before the mux output is sampled; legal range 1..15.
REQ-002 Parameter CONT, default 0: 1 selects continuous scanning, 0 selects single-shot scanning.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  scan request; sampled only in IDLE.
REQ-006 mux_out  input  1  output of the downstream 4-to-1 mux being scanned.
REQ-007 sel  output  2  select driven into the 4-to-1 mux.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 data  output  4  assembled word; data[i] is mux_out sampled while sel==i.
REQ-010 valid  output  1  data is available; held until the handshake completes.
REQ-011 ready  input  1  consumer accepts data when valid and ready are both high at a rising edge.
REQ-012 parity  output  1  even-parity bit of data; present only when SCAN_PARITY_EN is defined.

Function
REQ-013 The block shall implement a three-state FSM: IDLE, SCAN and DONE.
REQ-014 IDLE: sel=0 and valid=0; start=1 at an edge shall move the FSM to SCAN with sel=0 and dwell counter=0.
REQ-015 SCAN: the dwell counter shall increment each cycle.
REQ-016 When the counter equals DWELL-1 in SCAN, the block shall:
- capture mux_out into shadow bit [sel];
- clear the counter;
- increment sel if sel<3.
REQ-017 At the capture with sel==3, the block shall:
- load the complete shadow word into data;
- set valid=1;
- move to DONE.
REQ-018 Latency: valid shall rise exactly 4*DWELL rising edges after the edge that accepted start (8 edges for DWELL=2).
REQ-019 DONE: sel, data and valid shall hold stable while ready=0.
REQ-020 On valid&&ready in DONE, valid shall fall at that edge, and the FSM shall:
- go to IDLE if CONT=0;
- go to SCAN with sel=0 and counter=0 if CONT=1.
REQ-021 start while busy=1 shall be ignored; it shall not be queued.
REQ-022 ready while valid=0 shall have no effect.
REQ-023 data shall change only on word completion and shall retain the last word after the handshake.
REQ-024 sel shall wrap only through the return path (3 to DONE to 0) and never take an unsampled value.
REQ-025 With DWELL=1, one channel shall be sampled per cycle.

Reset
REQ-026 rst_n low shall, immediately and independent of clk:
- force the FSM to IDLE;
- set sel=0, data=0, valid=0, busy=0;
- clear the counter and the shadow word.
REQ-027 Reset asserted mid-scan shall discard the partial word; no valid shall follow after release without a new start.
REQ-028 In the first edge after rst_n deasserts, start shall be honoured normally.

Configuration
REQ-029 Macro SCAN_PARITY_EN defined: the parity port shall exist and equal XOR of data[3:0].
- parity shall be registered together with data.
- parity shall reset to 0.
REQ-030 Macro SCAN_PARITY_EN undefined: the parity port and its logic shall be absent; all other behaviour is unchanged.

Verification
Bench models the mux as mux_out = in[sel].
REQ-031 Single shot: DWELL=2, CONT=0, in=4'b1010, 1-cycle start, ready=1 -> sel steps 0,1,2,3 every 2 cycles; valid high 8 edges after start for 1 cycle; data=4'b1010; busy then falls.
REQ-032 Backpressure: in=4'b0110, ready=0 for 5 cycles after valid -> valid, data=4'b0110 and sel=3 stay stable; valid falls on the first edge with ready=1.
REQ-033 Start while busy: second start pulse at sel=1 -> ignored; exactly one valid; data=in.
REQ-034 Reset mid-scan: rst_n pulled low asynchronously at sel=2 -> sel=0, busy=0, valid=0, data=4'b0000 immediately; no valid after release until a new start.
REQ-035 Continuous mode: CONT=1, DWELL=1, in changes from 4'b1100 to 4'b0011 while DONE holds -> two words 4'b1100 then 4'b0011; the second valid occurs 4 edges after the first handshake.
REQ-036 Parity (SCAN_PARITY_EN defined): in=4'b0111 -> parity=1; in=4'b0101 -> parity=0.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 4-to-1 mux: steps sel 0..3, samples mux_out after DWELL cycles per channel,
// and presents the assembled word with a valid/ready handshake. Optional parity via SCAN_PARITY_EN.
module mux_scan_ctrl #(
    parameter int DWELL = 2,
    parameter int CONT  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mux_out,
    input  logic       ready,
    output logic [1:0] sel,
    output logic       busy,
    output logic [3:0] data,
    output logic       valid
`ifdef SCAN_PARITY_EN
    ,
    output logic       parity
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

    state_t     r_state,  w_state_nxt;
    logic [1:0] r_sel,    w_sel_nxt;
    logic [3:0] r_cnt,    w_cnt_nxt;
    logic [3:0] r_shadow, w_shadow_nxt;
    logic [3:0] r_data,   w_data_nxt;
    logic       r_valid,  w_valid_nxt;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_data_nxt   = r_data;
        w_valid_nxt  = r_valid;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SCAN;
                    w_sel_nxt   = 2'd0;
                    w_cnt_nxt   = 4'd0;
                end
            end

            ST_SCAN: begin
                if (r_cnt == DWELL_LAST) begin
                    w_cnt_nxt           = 4'd0;
                    w_shadow_nxt[r_sel] = mux_out;
                    if (r_sel == 2'd3) begin
                        // The final channel goes straight into data along with the earlier three.
                        w_data_nxt  = w_shadow_nxt;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_sel_nxt = r_sel + 2'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end

            ST_DONE: begin
                if (r_valid && ready) begin
                    w_valid_nxt = 1'b0;
                    w_sel_nxt   = 2'd0;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = (CONT != 0) ? ST_SCAN : ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_sel_nxt   = 2'd0;
                w_cnt_nxt   = 4'd0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_sel    <= 2'd0;
            r_cnt    <= 4'd0;
            r_shadow <= 4'd0;
            r_data   <= 4'd0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
            r_data   <= w_data_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

`ifdef SCAN_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (r_state == ST_SCAN && w_state_nxt == ST_DONE) begin
            r_parity <= ^w_data_nxt;
        end
    end

    assign parity = r_parity;
`endif

    assign sel   = r_sel;
    assign busy  = (r_state != ST_IDLE);
    assign data  = r_data;
    assign valid = r_valid;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: a single-shot DWELL=2 instance and a continuous DWELL=1
// instance, each driven from a behavioural 4-to-1 mux; expected words flow through scoreboard queues.
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Single-shot instance (DWELL=2, CONT=0)
    logic       start = 1'b0;
    logic       ready = 1'b0;
    logic [3:0] in_a  = 4'b0000;
    logic       mux_out;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] data;
    logic       valid;

    // Continuous instance (DWELL=1, CONT=1)
    logic       start_c = 1'b0;
    logic       ready_c = 1'b0;
    logic [3:0] in_c    = 4'b0000;
    logic       mux_out_c;
    logic [1:0] sel_c;
    logic       busy_c;
    logic [3:0] data_c;
    logic       valid_c;

`ifdef SCAN_PARITY_EN
    logic parity;
    logic parity_c;
`endif

    assign mux_out   = in_a[sel];
    assign mux_out_c = in_c[sel_c];

    mux_scan_ctrl #(.DWELL(2), .CONT(0)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mux_out (mux_out),
        .ready   (ready),
        .sel     (sel),
        .busy    (busy),
        .data    (data),
        .valid   (valid)
`ifdef SCAN_PARITY_EN
        ,
        .parity  (parity)
`endif
    );

    mux_scan_ctrl #(.DWELL(1), .CONT(1)) u_dut_cont (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_c),
        .mux_out (mux_out_c),
        .ready   (ready_c),
        .sel     (sel_c),
        .busy    (busy_c),
        .data    (data_c),
        .valid   (valid_c)
`ifdef SCAN_PARITY_EN
        ,
        .parity  (parity_c)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] sb[$];
    logic [3:0] sb_c[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advances until valid (of the chosen instance) is seen, bounded by limit edges.
    task automatic wait_valid(input bit use_c, input int limit, output int edges);
        logic v;
        edges = 0;
        v = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            edges++;
            v = use_c ? valid_c : valid;
            if (v) break;
        end
        if (!v) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_valid: valid not seen after %0d edges (bound %0d)", edges, limit);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (sel !== 2'd0 || busy !== 1'b0 || valid !== 1'b0 || data !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: sel=%0d busy=%b valid=%b data=%b, required 0/0/0/0000", sel, busy, valid, data);
        end
        n_checks++;
        if (sel_c !== 2'd0 || busy_c !== 1'b0 || valid_c !== 1'b0 || data_c !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state_cont: sel=%0d busy=%b valid=%b data=%b, required 0/0/0/0000", sel_c, busy_c, valid_c, data_c);
        end
`ifdef SCAN_PARITY_EN
        n_checks++;
        if (parity !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_parity: got %b required 0", parity);
        end
`endif
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_shot();
        logic [1:0] exp_sel;
        logic [3:0] exp;
        in_a  = 4'b1010;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        sb.push_back(4'b1010);
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_sel = (k == 8) ? 2'd3 : 2'(k / 2);
            n_checks++;
            if (sel !== exp_sel || busy !== 1'b1 || valid !== (k == 8)) begin
                n_fail++;
                $display("FAIL single_step%0d: sel=%0d busy=%b valid=%b, required sel=%0d busy=1 valid=%b", k, sel, busy, valid, exp_sel, (k == 8));
            end
            if (k == 8) begin
                exp = sb.pop_front();
                n_checks++;
                if (data !== exp) begin
                    n_fail++;
                    $display("FAIL single_data: got %b required %b", data, exp);
                end
            end
        end
        tick();
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || sel !== 2'd0 || data !== 4'b1010) begin
            n_fail++;
            $display("FAIL single_after: valid=%b busy=%b sel=%0d data=%b, required 0/0/0/1010", valid, busy, sel, data);
        end
        ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int edges;
        logic [3:0] exp;
        in_a  = 4'b0110;
        ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        sb.push_back(4'b0110);
        wait_valid(1'b0, 20, edges);
        n_checks++;
        if (edges !== 8) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d edges required 8", edges);
        end
        exp = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (valid !== 1'b1 || data !== exp || sel !== 2'd3) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b data=%b sel=%0d, required 1/%b/3", k, valid, data, sel, exp);
            end
            tick();
        end
        ready = 1'b1;
        tick();
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || data !== exp) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b busy=%b data=%b, required 0/0/%b", valid, busy, data, exp);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (valid !== 1'b0 || busy !== 1'b0 || data !== exp) begin
                n_fail++;
                $display("FAIL idle_ready%0d: valid=%b busy=%b data=%b, required 0/0/%b", k, valid, busy, data, exp);
            end
        end
        ready = 1'b0;
    endtask

    task automatic test_start_while_busy();
        int edges;
        int n_valid;
        logic [3:0] exp;
        in_a  = 4'b1001;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        sb.push_back(4'b1001);
        tick();
        tick();
        n_checks++;
        if (sel !== 2'd1) begin
            n_fail++;
            $display("FAIL busy_sel: got %0d required 1", sel);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(1'b0, 20, edges);
        n_checks++;
        if (edges + 3 !== 8) begin
            n_fail++;
            $display("FAIL busy_latency: got %0d edges required 8", edges + 3);
        end
        exp = sb.pop_front();
        n_checks++;
        if (data !== exp) begin
            n_fail++;
            $display("FAIL busy_data: got %b required %b", data, exp);
        end
        n_valid = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (valid) n_valid++;
        end
        n_checks++;
        if (n_valid !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_extra: extra valid cycles=%0d busy=%b, required 0/0", n_valid, busy);
        end
        ready = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        int edges;
        int n_valid;
        logic [3:0] exp;
        in_a  = 4'b1111;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        sb.push_back(4'b1111);
        for (int k = 0; k < 4; k++) tick();
        n_checks++;
        if (sel !== 2'd2) begin
            n_fail++;
            $display("FAIL rst_pre_sel: got %0d required 2", sel);
        end
        #3 rst_n = 1'b0;
        sb.delete();
        #1;
        n_checks++;
        if (sel !== 2'd0 || busy !== 1'b0 || valid !== 1'b0 || data !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_async: sel=%0d busy=%b valid=%b data=%b, required 0/0/0/0000", sel, busy, valid, data);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        n_valid = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (valid || busy) n_valid++;
        end
        n_checks++;
        if (n_valid !== 0) begin
            n_fail++;
            $display("FAIL rst_no_valid: active cycles=%0d required 0", n_valid);
        end
        // Start held across reset release must be accepted on the first edge.
        in_a  = 4'b0101;
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        start = 1'b0;
        sb.push_back(4'b0101);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_first_edge: busy=%b required 1", busy);
        end
        wait_valid(1'b0, 20, edges);
        n_checks++;
        if (edges !== 8) begin
            n_fail++;
            $display("FAIL rst_restart_latency: got %0d edges required 8", edges);
        end
        exp = sb.pop_front();
        n_checks++;
        if (data !== exp) begin
            n_fail++;
            $display("FAIL rst_restart_data: got %b required %b", data, exp);
        end
        tick();
        ready = 1'b0;
    endtask

    task automatic test_continuous();
        int edges;
        logic [3:0] exp;
        in_c    = 4'b1100;
        ready_c = 1'b0;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        sb_c.push_back(4'b1100);
        wait_valid(1'b1, 12, edges);
        n_checks++;
        if (edges !== 4) begin
            n_fail++;
            $display("FAIL cont_latency1: got %0d edges required 4", edges);
        end
        exp = sb_c.pop_front();
        tick();
        in_c = 4'b0011;
        sb_c.push_back(4'b0011);
        tick();
        n_checks++;
        if (valid_c !== 1'b1 || data_c !== exp || sel_c !== 2'd3) begin
            n_fail++;
            $display("FAIL cont_word1: valid=%b data=%b sel=%0d, required 1/%b/3", valid_c, data_c, sel_c, exp);
        end
        ready_c = 1'b1;
        tick();
        ready_c = 1'b0;
        n_checks++;
        if (valid_c !== 1'b0 || busy_c !== 1'b1 || sel_c !== 2'd0) begin
            n_fail++;
            $display("FAIL cont_restart: valid=%b busy=%b sel=%0d, required 0/1/0", valid_c, busy_c, sel_c);
        end
        wait_valid(1'b1, 12, edges);
        n_checks++;
        if (edges !== 4) begin
            n_fail++;
            $display("FAIL cont_latency2: got %0d edges required 4", edges);
        end
        exp = sb_c.pop_front();
        n_checks++;
        if (data_c !== exp) begin
            n_fail++;
            $display("FAIL cont_word2: got %b required %b", data_c, exp);
        end
    endtask

`ifdef SCAN_PARITY_EN
    task automatic test_parity();
        int edges;
        logic [3:0] words [2];
        logic [3:0] exp;
        words[0] = 4'b0111;
        words[1] = 4'b0101;
        ready = 1'b1;
        for (int w = 0; w < 2; w++) begin
            in_a  = words[w];
            start = 1'b1;
            tick();
            start = 1'b0;
            sb.push_back(words[w]);
            wait_valid(1'b0, 20, edges);
            exp = sb.pop_front();
            n_checks++;
            if (data !== exp || parity !== ^exp) begin
                n_fail++;
                $display("FAIL parity%0d: data=%b parity=%b, required %b/%b", w, data, parity, exp, ^exp);
            end
            tick();
        end
        ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_shot();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_scan();
        test_continuous();
`ifdef SCAN_PARITY_EN
        test_parity();
`endif
        n_checks++;
        if (sb.size() !== 0 || sb_c.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: left %0d/%0d entries, required 0/0", sb.size(), sb_c.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
